// File: rtl/mem_arbiter.sv
// Two-requester round-robin front end for a single-port word RAM.
// Reads fetch a whole aligned block word by word. Writes store a single word.
module mem_arbiter #(
  parameter int RAM_ADDRESS_BITS = 10,
  parameter int DATA_BITS        = 32,
  parameter int BLOCK_BITS       = 2,
  localparam int BLOCK_SIZE      = 2 ** BLOCK_BITS
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [1:0][RAM_ADDRESS_BITS-1:0]       req_address,
  input  logic [1:0]                             req_read_en,
  input  logic [1:0]                             req_write_en,
  input  logic [1:0][DATA_BITS-1:0]              req_write_data,
  output logic [1:0]                             resp_valid,
  output logic [BLOCK_SIZE-1:0][DATA_BITS-1:0]   resp_data,
  output logic [RAM_ADDRESS_BITS-1:0]            mem_address,
  output logic                                   mem_read_en,
  output logic                                   mem_write_en,
  output logic [DATA_BITS-1:0]                   mem_write_data,
  input  logic [DATA_BITS-1:0]                   mem_read_data,
  input  logic                                   mem_ack
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t                                state_q, state_d;
  logic                                  grant_q, grant_d;
  logic                                  last_grant_q, last_grant_d;
  logic [RAM_ADDRESS_BITS-1:0]           addr_q, addr_d;
  logic [DATA_BITS-1:0]                  wdata_q, wdata_d;
  logic [BLOCK_BITS-1:0]                 k_q, k_d;
  logic [BLOCK_SIZE-1:0][DATA_BITS-1:0]  buf_q, buf_d;
  logic [1:0][1:0]                       mask_q, mask_d;
  logic [1:0]                            resp_valid_q, resp_valid_d;
  logic [RAM_ADDRESS_BITS-1:0]           mem_address_q, mem_address_d;
  logic                                  mem_read_en_q, mem_read_en_d;
  logic                                  mem_write_en_q, mem_write_en_d;
  logic [DATA_BITS-1:0]                  mem_write_data_q, mem_write_data_d;

  logic [1:0] eligible;
  logic       sel;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      eligible[i] = (req_read_en[i] | req_write_en[i]) & (mask_q[i] == 2'd0);
    end
    if (eligible == 2'b11) sel = ~last_grant_q;
    else                   sel = eligible[1];
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    k_d          = k_q;
    buf_d        = buf_q;
    for (int i = 0; i < 2; i++) begin
      mask_d[i] = (mask_q[i] != 2'd0) ? mask_q[i] - 2'd1 : 2'd0;
    end

    case (state_q)
      IDLE: begin
        if (eligible != 2'b00) begin
          grant_d      = sel;
          last_grant_d = sel;
          addr_d       = req_address[sel];
          wdata_d      = req_write_data[sel];
          k_d          = '0;
          state_d      = req_write_en[sel] ? WRITE : READ;
        end
      end
      READ: begin
        if (mem_ack) begin
          buf_d[k_q] = mem_read_data;
          k_d        = k_q + 1'b1;  // wraps back to 0 after the last word
          if (k_q == {BLOCK_BITS{1'b1}}) state_d = RESP;
        end
      end
      WRITE: begin
        if (mem_ack) state_d = RESP;
      end
      RESP: begin
        // Holds the requester off while the cache's registered valid catches up.
        mask_d[grant_q] = 2'd2;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase

    mem_read_en_d    = (state_d == READ);
    mem_write_en_d   = (state_d == WRITE);
    mem_write_data_d = (state_d == WRITE) ? wdata_d : '0;
    if (state_d == READ)       mem_address_d = {addr_d[RAM_ADDRESS_BITS-1:BLOCK_BITS], k_d};
    else if (state_d == WRITE) mem_address_d = addr_d;
    else                       mem_address_d = '0;
    resp_valid_d = (state_d == RESP) ? (grant_d ? 2'b10 : 2'b01) : 2'b00;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      grant_q          <= 1'b0;
      last_grant_q     <= 1'b1;
      addr_q           <= '0;
      wdata_q          <= '0;
      k_q              <= '0;
      buf_q            <= '0;
      mask_q           <= '0;
      resp_valid_q     <= '0;
      mem_address_q    <= '0;
      mem_read_en_q    <= 1'b0;
      mem_write_en_q   <= 1'b0;
      mem_write_data_q <= '0;
    end else begin
      state_q          <= state_d;
      grant_q          <= grant_d;
      last_grant_q     <= last_grant_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      k_q              <= k_d;
      buf_q            <= buf_d;
      mask_q           <= mask_d;
      resp_valid_q     <= resp_valid_d;
      mem_address_q    <= mem_address_d;
      mem_read_en_q    <= mem_read_en_d;
      mem_write_en_q   <= mem_write_en_d;
      mem_write_data_q <= mem_write_data_d;
    end
  end

  assign resp_valid     = resp_valid_q;
  assign resp_data      = buf_q;
  assign mem_address    = mem_address_q;
  assign mem_read_en    = mem_read_en_q;
  assign mem_write_en   = mem_write_en_q;
  assign mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the RAM returns its own word address as data,
// and acks either automatically in the strobe cycle or under manual control.
module tb_mem_arbiter;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic [1:0][9:0]       req_address = '0;
  logic [1:0]            req_read_en = '0;
  logic [1:0]            req_write_en = '0;
  logic [1:0][31:0]      req_write_data = '0;
  logic [1:0]            resp_valid;
  logic [3:0][31:0]      resp_data;
  logic [9:0]            mem_address;
  logic                  mem_read_en;
  logic                  mem_write_en;
  logic [31:0]           mem_write_data;
  logic [31:0]           mem_read_data;
  logic                  mem_ack;
  logic                  ack_auto = 1'b1;
  logic                  ack_force = 1'b0;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  assign mem_read_data = {22'd0, mem_address};
  assign mem_ack       = ack_auto ? (mem_read_en | mem_write_en) : ack_force;

  mem_arbiter #(.RAM_ADDRESS_BITS(10), .DATA_BITS(32), .BLOCK_BITS(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_address(req_address), .req_read_en(req_read_en),
    .req_write_en(req_write_en), .req_write_data(req_write_data),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .mem_address(mem_address), .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_ack(mem_ack)
  );

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) @(negedge clk);
  endtask

  task automatic wait_resp(input int budget, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (resp_valid != 2'b00) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_cycles(2);
    checks++; if (resp_valid !== 2'b00) $display("FAIL reset_resp_valid got %b want 00", resp_valid); else passed++;
    checks++; if (resp_data !== '0) $display("FAIL reset_resp_data got %h want 0", resp_data); else passed++;
    checks++; if (mem_read_en !== 1'b0 || mem_write_en !== 1'b0) $display("FAIL reset_strobes got %b%b want 00", mem_read_en, mem_write_en); else passed++;
    checks++; if (mem_address !== 10'd0 || mem_write_data !== 32'd0) $display("FAIL reset_addr_data got %h/%h want 0/0", mem_address, mem_write_data); else passed++;
    reset_n = 1'b1;
    // Stray acks while idle must not start anything.
    ack_auto = 1'b0; ack_force = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (mem_read_en !== 1'b0 || mem_write_en !== 1'b0 || resp_valid !== 2'b00)
        $display("FAIL idle_ack cycle %0d got rd=%b wr=%b rv=%b want 0 0 00", c, mem_read_en, mem_write_en, resp_valid);
      else passed++;
    end
    ack_force = 1'b0; ack_auto = 1'b1;
    $display("txn reset done");
  endtask

  task automatic test_single_read();
    bit seen;
    req_address[0] = 10'h2A6; req_read_en[0] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      checks++; if (mem_read_en !== 1'b1 || mem_address !== 10'h2A4 + 10'(j))
        $display("FAIL read_word %0d got en=%b addr=%h want 1 %h", j, mem_read_en, mem_address, 10'h2A4 + 10'(j));
      else passed++;
      if (j == 0) begin
        req_read_en[0] = 1'b0; req_address[0] = 10'h3FF;
      end
    end
    @(negedge clk);
    checks++; if (resp_valid !== 2'b01) $display("FAIL read_resp_valid got %b want 01", resp_valid); else passed++;
    checks++; if (mem_read_en !== 1'b0 || mem_address !== 10'd0) $display("FAIL read_resp_idle_port got en=%b addr=%h want 0 0", mem_read_en, mem_address); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (resp_data[i] !== 32'h2A4 + 32'(i)) $display("FAIL read_data[%0d] got %h want %h", i, resp_data[i], 32'h2A4 + 32'(i)); else passed++;
    end
    @(negedge clk);
    checks++; if (resp_valid !== 2'b00) $display("FAIL read_resp_one_cycle got %b want 00", resp_valid); else passed++;
    $display("txn read req0 addr 2a6 data %h", resp_data);
    seen = 1'b0;
    idle_cycles(3);
  endtask

  task automatic test_contention();
    bit seen;
    logic [1:0] pulses [4];
    logic [1:0] want;
    int n = 0;
    reset_n = 1'b0;
    req_address[0] = 10'h100; req_address[1] = 10'h200;
    req_read_en = 2'b11;
    @(negedge clk);
    reset_n = 1'b1;
    for (int p = 0; p < 4; p++) begin
      wait_resp(20, seen);
      checks++; if (!seen) $display("FAIL contention_timeout pulse %0d got none want pulse", p); else passed++;
      if (!seen) break;
      pulses[n] = resp_valid;
      n++;
      $display("txn contention pulse %0d resp_valid %b", p, resp_valid);
      if (n == 4) req_read_en = 2'b00;
    end
    req_read_en = 2'b00;
    for (int p = 0; p < n; p++) begin
      want = (p % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if (pulses[p] !== want) $display("FAIL contention_order %0d got %b want %b", p, pulses[p], want); else passed++;
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (resp_data[i] !== 32'h200 + 32'(i)) $display("FAIL contention_data[%0d] got %h want %h", i, resp_data[i], 32'h200 + 32'(i)); else passed++;
    end
    idle_cycles(4);
  endtask

  task automatic test_write_delay();
    ack_auto = 1'b0; ack_force = 1'b0;
    req_address[1] = 10'h013; req_write_data[1] = 32'hDEADBEEF; req_write_en[1] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++; if (mem_write_en !== 1'b1 || mem_read_en !== 1'b0 || mem_address !== 10'h013 || mem_write_data !== 32'hDEADBEEF)
        $display("FAIL write_hold %0d got wr=%b rd=%b addr=%h data=%h want 1 0 013 deadbeef", j, mem_write_en, mem_read_en, mem_address, mem_write_data);
      else passed++;
      checks++; if (resp_valid !== 2'b00) $display("FAIL write_early_resp %0d got %b want 00", j, resp_valid); else passed++;
      if (j == 0) req_write_en[1] = 1'b0;
      if (j == 2) ack_force = 1'b1;
    end
    @(negedge clk);
    ack_force = 1'b0;
    checks++; if (resp_valid !== 2'b10) $display("FAIL write_resp_valid got %b want 10", resp_valid); else passed++;
    checks++; if (mem_write_en !== 1'b0 || mem_address !== 10'd0) $display("FAIL write_resp_port got wr=%b addr=%h want 0 0", mem_write_en, mem_address); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (resp_data[i] !== 32'h200 + 32'(i)) $display("FAIL write_keeps_data[%0d] got %h want %h", i, resp_data[i], 32'h200 + 32'(i)); else passed++;
    end
    $display("txn write req1 addr 013 data deadbeef");
    ack_auto = 1'b1;
    idle_cycles(4);
  endtask

  task automatic test_mask();
    bit seen;
    req_address[0] = 10'h040; req_read_en[0] = 1'b1;
    wait_resp(20, seen);
    checks++; if (!seen || resp_valid !== 2'b01) $display("FAIL mask_first_resp got seen=%b rv=%b want 1 01", seen, resp_valid); else passed++;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++; if (mem_read_en !== 1'b0) $display("FAIL mask_blocked cycle %0d got rd=%b want 0", c, mem_read_en); else passed++;
    end
    @(negedge clk);
    checks++; if (mem_read_en !== 1'b1 || mem_address !== 10'h040) $display("FAIL mask_regrant got rd=%b addr=%h want 1 040", mem_read_en, mem_address); else passed++;
    req_read_en[0] = 1'b0;
    wait_resp(10, seen);
    checks++; if (!seen || resp_valid !== 2'b01) $display("FAIL mask_second_resp got seen=%b rv=%b want 1 01", seen, resp_valid); else passed++;
    $display("txn mask req0 re-read addr 040");
    idle_cycles(4);
  endtask

  task automatic test_rw_both();
    bit seen;
    int rd_seen = 0;
    req_address[0] = 10'h155; req_write_data[0] = 32'h12345678;
    req_read_en[0] = 1'b1; req_write_en[0] = 1'b1;
    @(negedge clk);
    checks++; if (mem_write_en !== 1'b1 || mem_read_en !== 1'b0 || mem_address !== 10'h155 || mem_write_data !== 32'h12345678)
      $display("FAIL rw_write got wr=%b rd=%b addr=%h data=%h want 1 0 155 12345678", mem_write_en, mem_read_en, mem_address, mem_write_data);
    else passed++;
    req_read_en[0] = 1'b0; req_write_en[0] = 1'b0;
    @(negedge clk);
    checks++; if (resp_valid !== 2'b01) $display("FAIL rw_resp got %b want 01", resp_valid); else passed++;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (mem_read_en) rd_seen++;
    end
    checks++; if (rd_seen !== 0) $display("FAIL rw_no_read got %0d read cycles want 0", rd_seen); else passed++;
    $display("txn rw req0 served as write addr 155");
    seen = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    bit seen;
    int rv_seen = 0;
    req_address[0] = 10'h081; req_read_en[0] = 1'b1;
    idle_cycles(3);
    checks++; if (mem_read_en !== 1'b1 || mem_address !== 10'h082) $display("FAIL midread_pos got rd=%b addr=%h want 1 082", mem_read_en, mem_address); else passed++;
    reset_n = 1'b0;
    req_read_en[0] = 1'b0;
    #1;
    checks++; if (mem_read_en !== 1'b0 || mem_address !== 10'd0) $display("FAIL async_reset_port got rd=%b addr=%h want 0 0", mem_read_en, mem_address); else passed++;
    checks++; if (resp_data !== '0) $display("FAIL async_reset_data got %h want 0", resp_data); else passed++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (resp_valid != 2'b00) rv_seen++;
    end
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (resp_valid != 2'b00) rv_seen++;
    end
    checks++; if (rv_seen !== 0) $display("FAIL abandoned_resp got %0d pulses want 0", rv_seen); else passed++;
    req_address[0] = 10'h0C1; req_read_en[0] = 1'b1;
    @(negedge clk);
    req_read_en[0] = 1'b0;
    checks++; if (mem_read_en !== 1'b1 || mem_address !== 10'h0C0) $display("FAIL restart_k0 got rd=%b addr=%h want 1 0c0", mem_read_en, mem_address); else passed++;
    wait_resp(10, seen);
    checks++; if (!seen || resp_valid !== 2'b01) $display("FAIL restart_resp got seen=%b rv=%b want 1 01", seen, resp_valid); else passed++;
    checks++; if (resp_data[0] !== 32'h0C0 || resp_data[3] !== 32'h0C3) $display("FAIL restart_data got %h want 0c3..0c0", resp_data); else passed++;
    $display("txn reset mid-read then read req0 addr 0c1");
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_write_delay();
    test_mask();
    test_rw_both();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
